// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// P has default priority; L is forced in after a bounded wait.
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_wren,
    input  logic [11:0] p_addr,
    input  logic [31:0] p_data,
    output logic        p_stall,
    output logic        p_rvalid,
    output logic [31:0] p_q,
    input  logic        l_req,
    input  logic        l_wren,
    input  logic [11:0] l_addr,
    input  logic [31:0] l_data,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_q,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    localparam logic [3:0] MW = 4'(MAX_WAIT);
    localparam logic [3:0] BL = 4'(BURST_LEN);

    typedef enum logic {S_PROC, S_LOAD} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_P, RD_L} owner_t;

    state_t     state;
    owner_t     rd_owner;
    logic [3:0] wait_cnt;
    logic [3:0] burst_cnt;
    logic       sel_raw;
    logic       sel_l;
    logic       p_issue;

    always_comb begin
        sel_raw = 1'b0;
        if (l_req) begin
            case (state)
                S_PROC: sel_raw = !p_req || (wait_cnt == MW);
                S_LOAD: sel_raw = !p_req || (burst_cnt < BL);
            endcase
        end
    end

    // Outputs are forced idle while reset is held, whatever the requests.
    assign sel_l   = reset && sel_raw;
    assign p_issue = reset && p_req && !sel_raw;

    assign l_gnt        = sel_l;
    assign p_stall      = p_req && sel_l;
    assign address_dmem = sel_l ? l_addr : p_addr;
    assign data         = sel_l ? l_data : p_data;
    assign wren         = sel_l ? l_wren : (p_issue && p_wren);

    assign p_rvalid = (rd_owner == RD_P);
    assign l_rvalid = (rd_owner == RD_L);
    assign p_q      = q_dmem;
    assign l_q      = q_dmem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_PROC;
            wait_cnt  <= 4'd0;
            burst_cnt <= 4'd0;
            rd_owner  <= RD_NONE;
        end else begin
            case (state)
                S_PROC: begin
                    if (sel_raw) begin
                        state     <= S_LOAD;
                        burst_cnt <= 4'd1;
                    end
                end
                S_LOAD: begin
                    if (!sel_raw) begin
                        state     <= S_PROC;
                        burst_cnt <= 4'd0;
                    end else if (p_req && burst_cnt != 4'hf) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
            endcase

            if (sel_raw || !l_req)
                wait_cnt <= 4'd0;
            else if (wait_cnt != MW)
                wait_cnt <= wait_cnt + 4'd1;

            // Tag the read so its data returns to whoever issued it.
            if (sel_raw && !l_wren)
                rd_owner <= RD_L;
            else if (!sel_raw && p_req && !p_wren)
                rd_owner <= RD_P;
            else
                rd_owner <= RD_NONE;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cycle model of the arbitration rules plus
// directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int BURST_LEN = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        p_req, p_wren;
    logic [11:0] p_addr;
    logic [31:0] p_data;
    logic        p_stall, p_rvalid;
    logic [31:0] p_q;
    logic        l_req, l_wren;
    logic [11:0] l_addr;
    logic [31:0] l_data;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_q;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_q(p_q),
        .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_q(l_q),
        .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem)
    );

    // Synchronous single-port memory, one-cycle read latency.
    logic [31:0] mem [0:4095];
    always @(posedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= mem[address_dmem];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: L gets a slot when P is idle, after MAX_WAIT
    // denied cycles, or while its run of grants under P load is short.
    int          denied = 0;
    int          streak = 0;
    int          pend = 0;
    logic [31:0] pend_q;
    logic [31:0] shadow [0:4095];

    always @(negedge clock) begin : model
        logic g;
        if (!reset) begin
            chk("rst_l_gnt", l_gnt, 0);
            chk("rst_p_stall", p_stall, 0);
            chk("rst_wren", wren, 0);
            chk("rst_p_rvalid", p_rvalid, 0);
            chk("rst_l_rvalid", l_rvalid, 0);
            denied = 0;
            streak = 0;
            pend = 0;
        end else begin
            if (!l_req) g = 1'b0;
            else if (!p_req) g = 1'b1;
            else if (streak == 0) g = (denied >= MAX_WAIT);
            else g = (streak < BURST_LEN);

            chk("m_l_gnt", l_gnt, g);
            chk("m_p_stall", p_stall, p_req && g);
            chk("m_wren", wren, g ? l_wren : (p_req && p_wren));
            chk("m_addr", address_dmem, g ? l_addr : p_addr);
            chk("m_data", data, g ? l_data : p_data);
            chk("m_p_rvalid", p_rvalid, pend == 1);
            chk("m_l_rvalid", l_rvalid, pend == 2);
            if (pend == 1) chk("m_p_q", p_q, pend_q);
            if (pend == 2) chk("m_l_q", l_q, pend_q);

            if (g) begin
                streak = (streak == 0) ? 1 : streak + (p_req ? 1 : 0);
                denied = 0;
            end else begin
                streak = 0;
                denied = l_req ? denied + 1 : 0;
            end

            pend = 0;
            if (g) begin
                if (l_wren) shadow[l_addr] = l_data;
                else begin pend = 2; pend_q = shadow[l_addr]; end
            end else if (p_req) begin
                if (p_wren) shadow[p_addr] = p_data;
                else begin pend = 1; pend_q = shadow[p_addr]; end
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [9:0] gv;
        reset = 1'b1;
        p_req = 0; p_wren = 0; p_addr = '0; p_data = '0;
        l_req = 0; l_wren = 0; l_addr = '0; l_data = '0;
        #1;
        reset = 1'b0;
        p_req = 1; p_wren = 1; p_addr = 12'h000; p_data = 32'h1;
        l_req = 1; l_addr = 12'h7FF;
        @(negedge clock);
        chk("rst_hold_gnt", l_gnt, 0);
        chk("rst_hold_wren", wren, 0);
        @(negedge clock);
        nxt();
        reset = 1'b1;
        @(negedge clock);
        chk("rel_gnt", l_gnt, 0);
        chk("rel_stall", p_stall, 0);
        chk("rel_wren", wren, 1);
        nxt();
        p_req = 0; l_req = 0;
        nxt();

        // P only: write then read back
        p_req = 1; p_wren = 1; p_addr = 12'h010; p_data = 32'hDEADBEEF;
        @(negedge clock);
        chk("p_wr_wren", wren, 1);
        nxt();
        p_wren = 0;
        @(negedge clock);
        chk("p_rd_wren", wren, 0);
        chk("p_rd_stall", p_stall, 0);
        nxt();
        p_req = 0;
        @(negedge clock);
        chk("p_rd_rvalid", p_rvalid, 1);
        chk("p_rd_q", p_q, 32'hDEADBEEF);
        nxt();

        // L only: preload then read
        l_req = 1; l_wren = 1; l_addr = 12'h7FF; l_data = 32'h12345678;
        @(negedge clock);
        chk("l_wr_gnt", l_gnt, 1);
        nxt();
        l_wren = 0;
        @(negedge clock);
        chk("l_rd_gnt", l_gnt, 1);
        nxt();
        l_req = 0;
        @(negedge clock);
        chk("l_rd_rvalid", l_rvalid, 1);
        chk("l_rd_q", l_q, 32'h12345678);
        chk("l_rd_p_rvalid", p_rvalid, 0);
        nxt();

        // Starvation under continuous P traffic
        p_req = 1; p_wren = 0; p_addr = 12'h010;
        l_req = 1; l_wren = 0; l_addr = 12'h7FF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            gv[k] = l_gnt;
            nxt();
        end
        chk("starve_gnt_pattern", 32'(gv), 32'h30);
        p_req = 0; l_req = 0;
        nxt();

        // L burst with P idle
        for (int i = 0; i < 8; i++) begin
            l_req = 1; l_wren = 1;
            l_addr = 12'h100 + 12'(i);
            l_data = 32'hC0DE0000 + 32'(i);
            @(negedge clock);
            chk("burst_wr_gnt", l_gnt, 1);
            nxt();
        end
        for (int i = 0; i <= 8; i++) begin
            l_req = (i < 8); l_wren = 0;
            l_addr = 12'h100 + 12'(i);
            @(negedge clock);
            if (i > 0) chk("burst_rd_q", l_q, 32'hC0DE0000 + 32'(i - 1));
            nxt();
        end
        l_req = 0;
        nxt();

        // Alternating owners: preload A and B
        p_req = 1; p_wren = 1; p_addr = 12'h0A0; p_data = 32'hAAAA0000;
        nxt();
        p_req = 0;
        l_req = 1; l_wren = 1; l_addr = 12'h0B0; l_data = 32'h0000BBBB;
        nxt();
        l_req = 0;
        nxt();
        p_req = 1; p_wren = 0; p_addr = 12'h0A0;
        l_req = 1; l_wren = 0; l_addr = 12'h0B0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("alt_wait_gnt", l_gnt, 0);
            nxt();
        end
        @(negedge clock);
        chk("alt_force_gnt", l_gnt, 1);
        chk("alt_force_stall", p_stall, 1);
        chk("alt_p_rvalid", p_rvalid, 1);
        chk("alt_p_q", p_q, 32'hAAAA0000);
        chk("alt_no_l_rvalid", l_rvalid, 0);
        nxt();
        @(negedge clock);
        chk("alt_l_rvalid", l_rvalid, 1);
        chk("alt_l_q", l_q, 32'h0000BBBB);
        chk("alt_no_p_rvalid", p_rvalid, 0);
        chk("alt_burst_gnt", l_gnt, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_gnt", l_gnt, 0);
        chk("midrst_stall", p_stall, 0);
        chk("midrst_wren", wren, 0);
        chk("midrst_l_rvalid", l_rvalid, 0);
        nxt();
        @(negedge clock);
        chk("midrst_l_rvalid2", l_rvalid, 0);
        nxt();
        reset = 1'b1;
        l_req = 0;
        @(negedge clock);
        chk("post_rst_l_rvalid", l_rvalid, 0);
        chk("post_rst_stall", p_stall, 0);
        nxt();
        p_req = 0;
        @(negedge clock);
        chk("reissue_p_rvalid", p_rvalid, 1);
        chk("reissue_p_q", p_q, 32'hAAAA0000);
        nxt();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
